uart_tx_fifo: RTL

Parametrised UART transmitter with an integrated transmit FIFO, configurable frame format (data width, parity, stop bits) and asynchronous active-low reset. It sits between any byte-producing logic (command responders, debug dumpers) and the board's serial TX pin. It lets producers push bursts without tracking bit timing. Consecutive frames go out back-to-back with no idle gap.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_fifo_if.sv | 23 ++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/uart_tx_fifo.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types for the UART blocks (transmitter now, receiver later).
//   parity_t   : frame parity mode (none / odd / even)
//   tx_state_t : transmitter FSM states
//   parity_bit : maps the XOR of the payload to the bit put on the line
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Even parity transmits the XOR of the data bits, odd parity its inverse.
    function automatic logic parity_bit(input parity_t mode, input logic data_xor);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_if
// Producer-side handshake of the UART transmitter.
//   data  : word to send (DATA_BITS wide)
//   valid : producer has a word; taken on an edge where valid && ready
//   ready : transmitter FIFO not full
//   level : current FIFO occupancy
// master = producer, slave = uart_tx_fifo.
// ----------------------------------------------------------------------------
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic [LVL_W-1:0]     level;

    modport master (output data, output valid, input ready, input level);
    modport slave  (input data, input valid, output ready, output level);
endinterface

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered storage and a first-word-fall-through
// read port (rd_data_o always shows the head entry).
//   clk, rst_n : clock, asynchronous active-low reset (pointers/level only)
//   push_i     : write wr_data_i (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   rd_data_o  : head entry
//   full_o, empty_o, level_o : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             push_ok, pop_ok;

    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter with an integrated transmit FIFO. Frames are
// start / DATA_BITS LSB-first / optional parity / STOP_BITS stop, and
// queued words go out back-to-back with no idle gap.
//   clk   : system clock
//   rst_n : asynchronous active-low reset; abandons any frame, tx high at once
//   bus   : producer handshake (data / valid / ready / level)
//   tx    : serial line, registered, idle high
//   busy  : a frame is on the line or the FIFO holds words
// ----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int      CLK_FREQ   = 12_000_000,
    parameter int      BAUD_RATE  = 115200,
    parameter int      DATA_BITS  = 8,
    parameter parity_t PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus,
    output logic           tx,
    output logic           busy
);
    localparam int CPB   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(CPB);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_t            state_q;
    logic [CNT_W-1:0]     cyc_q;
    logic [BIT_W-1:0]     bit_q;
    logic                 stop_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 tx_q;
    logic                 busy_q;

    logic [DATA_BITS-1:0] fifo_rd;
    logic                 fifo_full, fifo_empty;
    logic [LVL_W-1:0]     fifo_level;
    logic                 push, pop;
    logic                 bit_end, last_stop;

    assign push      = bus.valid && bus.ready;
    assign bus.ready = !fifo_full;
    assign bus.level = fifo_level;

    assign bit_end   = (cyc_q == CNT_W'(CPB - 1));
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_q;

    // The head is taken either from IDLE or on the very last stop-bit cycle,
    // which is what makes consecutive frames abut with no idle cycle.
    assign pop = !fifo_empty &&
                 ((state_q == ST_IDLE) ||
                  (state_q == ST_STOP && bit_end && last_stop));

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .wr_data_i (bus.data),
        .pop_i     (pop),
        .rd_data_o (fifo_rd),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    // Payload shift register and precomputed parity, loaded on pop.
    always_ff @(posedge clk) begin
        if (pop) begin
            shift_q <= fifo_rd;
            par_q   <= parity_bit(PARITY, ^fifo_rd);
        end else if (state_q == ST_DATA && bit_end) begin
            shift_q <= shift_q >> 1;
        end
    end

    // FSM. tx and busy are registered from the current state, so the line
    // trails the state by one cycle uniformly and every bit keeps its length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= (state_q != ST_IDLE) || !fifo_empty;

            case (state_q)
                ST_START:  tx_q <= 1'b0;
                ST_DATA:   tx_q <= shift_q[0];
                ST_PARITY: tx_q <= par_q;
                default:   tx_q <= 1'b1;
            endcase

            case (state_q)
                ST_IDLE: begin
                    cyc_q <= '0;
                    if (!fifo_empty) begin
                        state_q <= ST_START;
                    end
                end

                ST_START: begin
                    if (bit_end) begin
                        cyc_q   <= '0;
                        bit_q   <= '0;
                        state_q <= ST_DATA;
                    end else begin
                        cyc_q <= cyc_q + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        cyc_q <= '0;
                        if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                            bit_q   <= '0;
                            stop_q  <= 1'b0;
                            state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        cyc_q <= cyc_q + CNT_W'(1);
                    end
                end

                ST_PARITY: begin
                    if (bit_end) begin
                        cyc_q   <= '0;
                        stop_q  <= 1'b0;
                        state_q <= ST_STOP;
                    end else begin
                        cyc_q <= cyc_q + CNT_W'(1);
                    end
                end

                ST_STOP: begin
                    if (bit_end) begin
                        cyc_q <= '0;
                        if (last_stop) begin
                            stop_q  <= 1'b0;
                            state_q <= fifo_empty ? ST_IDLE : ST_START;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end else begin
                        cyc_q <= cyc_q + CNT_W'(1);
                    end
                end

                default: begin
                    cyc_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule
